dsp_macc_pipe: RTL
==================

DSP_MACC_PIPE -- requirements
Module: dsp_macc_pipe

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- A_WIDTH, 18, signed A operand width.
- B_WIDTH, 18, signed B and D operand width.
- P_WIDTH, 48, accumulator, C and P width; the block SHALL NOT elaborate unless P_WIDTH >= A_WIDTH+B_WIDTH+1.
- M_STAGES, 2, product pipeline depth, legal range 1..4.
- ACC_LEN, 4, number of terms per frame, legal range 1..65535.
- SATURATE, 1; 1 = clamp on overflow, 0 = wrap.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- CLK, in, 1, single clock; every register samples on the rising edge.
- RST, in, 1, synchronous, active-high reset.
- CE, in, 1, global clock enable; 0 stalls the whole pipeline.
- IN_VALID, in, 1, operands valid this cycle.
- IN_LAST, in, 1, forces frame end on this term.
- A, in, A_WIDTH, signed.
- B, in, B_WIDTH, signed.
- D, in, B_WIDTH, signed pre-adder operand.
- C, in, P_WIDTH, signed preload value.
- PREADD_EN, in, 1, 1: use D+B, 0: use B.
- SUB, in, 1, 1: subtract the term from the accumulator.
- LOAD_C, in, 1, first term of a frame adds C.
- P, out, P_WIDTH, last completed frame result.
- P_VALID, out, 1, one-cycle result strobe.
- P_OVF, out, 1, overflow occurred in the frame held on P.
- CNT, out, 16, terms accumulated so far in the current frame.

Function
REQ-003 Stage 0 SHALL register A, B, D, C and the control bits (IN_VALID, IN_LAST, PREADD_EN, SUB, LOAD_C) when CE=1.
REQ-004 The pre-adder SHALL compute D+B at B_WIDTH+1 bits, sign-extended, without overflow; PREADD_EN=0 SHALL pass B sign-extended.
REQ-005 The product SHALL be A times the pre-adder output, signed, A_WIDTH+B_WIDTH+1 bits, and SHALL travel through M_STAGES registers together with its valid and control bits.
REQ-006 At the accumulate stage, a valid term SHALL update ACC as follows:
- first term of a frame (CNT=0): ACC = (LOAD_C ? C : 0) ± product;
- otherwise: ACC = ACC ± product;
- the sign is minus when SUB=1.
REQ-007 The sum SHALL be formed at P_WIDTH+1 bits. On signed overflow:
- SATURATE=1: clamp to 2^(P_WIDTH-1)-1 or -2^(P_WIDTH-1);
- SATURATE=0: keep the low P_WIDTH bits;
- in both cases set the frame-sticky overflow flag.
REQ-008 CNT SHALL increment on each valid term. When CNT=ACC_LEN-1, or the term carries IN_LAST, the frame SHALL end: P gets the final ACC, P_OVF gets the sticky flag, P_VALID pulses for exactly one cycle, and CNT and the sticky flag clear.
REQ-009 Latency: a term sampled at edge t SHALL affect ACC at edge t+M_STAGES+1, and its frame result SHALL appear on P/P_VALID after that same edge.
REQ-010 Terms with IN_VALID=0 SHALL be bubbles. A bubble SHALL NOT change ACC, CNT, P, P_OVF, or assert P_VALID.
REQ-011 With CE=0, every register SHALL hold (including CNT and ACC), P_VALID SHALL be 0, and inputs SHALL be ignored. No in-flight term SHALL be lost or duplicated across a stall.
REQ-012 Back-to-back frames SHALL need no idle cycle: the term after a frame end SHALL be treated as CNT=0.
REQ-013 P and P_OVF SHALL hold their value between frame ends.

Reset
REQ-014 RST=1 at a rising edge SHALL clear, regardless of CE: all pipeline valids, ACC, the sticky flag, CNT, P, P_OVF and P_VALID; P and CNT clear to 0.
REQ-015 A reset mid-frame SHALL discard the partial frame and all in-flight terms. The first valid term after RST deasserts SHALL start a new frame with CNT=0.

Structure
REQ-016 Default widths, the legal M_STAGES and ACC_LEN ranges, and the CNT width (16) SHALL live in a shared package dsp_macc_pkg.
REQ-017 The product pipeline SHALL be built from one sub-module, pipe_stage: a parametrised data+valid register with CE and synchronous RST, instantiated M_STAGES times.

Verification (defaults unless stated)
REQ-018 Assert RST for 2 cycles with random inputs -> P=0, P_VALID=0, P_OVF=0, CNT=0.
REQ-019 Drive A=3, B=5 with IN_VALID=1 for 4 consecutive cycles -> a single P_VALID pulse 3 edges after the 4th sample edge, with P=60 and P_OVF=0.
REQ-020 Drive PREADD_EN=1, D=10, B=-4, A=2 for 4 terms, with SUB=1 on the 2nd term -> P=24.
REQ-021 Drive LOAD_C=1, C=2^47-1, A=1, B=1, then 3 zero terms -> P=2^47-1, P_OVF=1. With SATURATE=0 the same stimulus -> P=-2^47, P_OVF=1.
REQ-022 Drive 2 terms A=1, B=7, IN_LAST=1 on the 2nd, with CE=0 for 3 cycles between them -> P=14, P_VALID delayed by exactly 3 cycles, and the next frame starts at CNT=0.
REQ-023 Drive 2 valid terms, then RST for 1 cycle, then 4 terms A=B=1 -> exactly one P_VALID, with P=4.

Source files
------------

// File: rtl/dsp_macc_pkg.sv
// Shared defaults and legal ranges for the pipelined multiply-accumulate.
// Imported by the MAC top and its product pipeline stage.
package dsp_macc_pkg;

  localparam int DEF_A_WIDTH  = 18;
  localparam int DEF_B_WIDTH  = 18;
  localparam int DEF_P_WIDTH  = 48;
  localparam int DEF_M_STAGES = 2;
  localparam int DEF_ACC_LEN  = 4;
  localparam int DEF_SATURATE = 1;

  localparam int M_STAGES_MIN = 1;
  localparam int M_STAGES_MAX = 4;
  localparam int ACC_LEN_MIN  = 1;
  localparam int ACC_LEN_MAX  = 65535;
  localparam int CNT_WIDTH    = 16;

  function automatic bit in_range(int v, int lo, int hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/dsp_macc_pipe_stage.sv
// One register slice of the product pipeline: data plus valid,
// advancing only on CE, valid cleared by synchronous reset.
module pipe_stage #(
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
    end else if (ce_i) begin
      valid_q <= valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/dsp_macc_pipe.sv
// Pre-add, multiply and frame accumulate with optional saturation.
// Result is published on P with a one-cycle P_VALID strobe per frame.
module dsp_macc_pipe
  import dsp_macc_pkg::*;
#(
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int B_WIDTH  = DEF_B_WIDTH,
  parameter int P_WIDTH  = DEF_P_WIDTH,
  parameter int M_STAGES = DEF_M_STAGES,
  parameter int ACC_LEN  = DEF_ACC_LEN,
  parameter int SATURATE = DEF_SATURATE
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CE,
  input  logic                 IN_VALID,
  input  logic                 IN_LAST,
  input  logic [A_WIDTH-1:0]   A,
  input  logic [B_WIDTH-1:0]   B,
  input  logic [B_WIDTH-1:0]   D,
  input  logic [P_WIDTH-1:0]   C,
  input  logic                 PREADD_EN,
  input  logic                 SUB,
  input  logic                 LOAD_C,
  output logic [P_WIDTH-1:0]   P,
  output logic                 P_VALID,
  output logic                 P_OVF,
  output logic [CNT_WIDTH-1:0] CNT
);

  localparam int PA_W = B_WIDTH + 1;
  localparam int PR_W = A_WIDTH + B_WIDTH + 1;
  localparam int PL_W = PR_W + P_WIDTH + 3;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(ACC_LEN - 1);
  localparam logic signed [P_WIDTH-1:0] SAT_MAX =
    {1'b0, {(P_WIDTH-1){1'b1}}};
  localparam logic signed [P_WIDTH-1:0] SAT_MIN =
    {1'b1, {(P_WIDTH-1){1'b0}}};

  if (P_WIDTH < PR_W) begin : g_bad_pw
    $error("P_WIDTH too narrow for the product");
  end
  if (!in_range(M_STAGES, M_STAGES_MIN, M_STAGES_MAX)) begin : g_bad_ms
    $error("M_STAGES out of range");
  end
  if (!in_range(ACC_LEN, ACC_LEN_MIN, ACC_LEN_MAX)) begin : g_bad_al
    $error("ACC_LEN out of range");
  end

  logic                      s0_v_q;
  logic                      s0_last_q;
  logic                      s0_pre_q;
  logic                      s0_sub_q;
  logic                      s0_ldc_q;
  logic signed [A_WIDTH-1:0] s0_a_q;
  logic signed [B_WIDTH-1:0] s0_b_q;
  logic signed [B_WIDTH-1:0] s0_d_q;
  logic signed [P_WIDTH-1:0] s0_c_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      s0_v_q <= 1'b0;
    end else if (CE) begin
      s0_v_q    <= IN_VALID;
      s0_last_q <= IN_LAST;
      s0_pre_q  <= PREADD_EN;
      s0_sub_q  <= SUB;
      s0_ldc_q  <= LOAD_C;
      s0_a_q    <= A;
      s0_b_q    <= B;
      s0_d_q    <= D;
      s0_c_q    <= C;
    end
  end

  logic signed [PA_W-1:0] pre;
  logic signed [PR_W-1:0] prod;

  assign pre  = s0_pre_q ? PA_W'(s0_d_q) + PA_W'(s0_b_q)
                         : PA_W'(s0_b_q);
  assign prod = PR_W'(s0_a_q) * PR_W'(pre);

  // Product and its controls travel together so a stall never splits them.
  logic [M_STAGES:0][PL_W-1:0] pl_d;
  logic [M_STAGES:0]           pl_v;

  assign pl_d[0] = {prod, s0_c_q, s0_last_q, s0_sub_q, s0_ldc_q};
  assign pl_v[0] = s0_v_q;

  for (genvar i = 0; i < M_STAGES; i++) begin : g_pipe
    pipe_stage #(
      .WIDTH(PL_W)
    ) u_stage (
      .clk_i  (CLK),
      .rst_i  (RST),
      .ce_i   (CE),
      .valid_i(pl_v[i]),
      .data_i (pl_d[i]),
      .valid_o(pl_v[i+1]),
      .data_o (pl_d[i+1])
    );
  end

  logic signed [PR_W-1:0]    m_prod;
  logic signed [P_WIDTH-1:0] m_c;
  logic                      m_last;
  logic                      m_sub;
  logic                      m_ldc;
  logic                      m_v;

  assign {m_prod, m_c, m_last, m_sub, m_ldc} = pl_d[M_STAGES];
  assign m_v = pl_v[M_STAGES];

  logic signed [P_WIDTH-1:0] acc_q, acc_d;
  logic signed [P_WIDTH-1:0] p_q, p_d;
  logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;
  logic                      sticky_q, sticky_d;
  logic                      povf_q, povf_d;
  logic                      pvalid_q, pvalid_d;

  logic signed [P_WIDTH:0]   base;
  logic signed [P_WIDTH:0]   term;
  logic signed [P_WIDTH:0]   sum;
  logic signed [P_WIDTH-1:0] res;
  logic                      ovf;
  logic                      fin;

  always_comb begin
    if (cnt_q == '0) begin
      base = m_ldc ? (P_WIDTH+1)'(m_c) : '0;
    end else begin
      base = (P_WIDTH+1)'(acc_q);
    end
    term = (P_WIDTH+1)'(m_prod);
    sum  = m_sub ? base - term : base + term;
    // One guard bit: overflow when it disagrees with the result sign.
    ovf  = sum[P_WIDTH] ^ sum[P_WIDTH-1];
    res  = sum[P_WIDTH-1:0];
    if (ovf && (SATURATE != 0)) begin
      res = sum[P_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    fin  = m_last || (cnt_q == LAST_CNT);
  end

  always_comb begin
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    p_d      = p_q;
    povf_d   = povf_q;
    pvalid_d = 1'b0;
    if (CE && m_v) begin
      acc_d = res;
      if (fin) begin
        cnt_d    = '0;
        sticky_d = 1'b0;
        p_d      = res;
        povf_d   = sticky_q | ovf;
        pvalid_d = 1'b1;
      end else begin
        cnt_d    = cnt_q + CNT_WIDTH'(1);
        sticky_d = sticky_q | ovf;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      p_q      <= '0;
      povf_q   <= 1'b0;
      pvalid_q <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
      p_q      <= p_d;
      povf_q   <= povf_d;
      pvalid_q <= pvalid_d;
    end
  end

  assign P       = p_q;
  assign P_VALID = pvalid_q;
  assign P_OVF   = povf_q;
  assign CNT     = cnt_q;

endmodule
